// File: rtl/app_pattern_driver.sv
// Stimulus driver for an approximate-adder error checker. It sweeps 8-bit {b,a} patterns,
// either exhaustively or in LFSR order, and counts and records failures reported on err_in.
module app_pattern_driver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] seed,
    input  logic       abort,
    input  logic       err_in,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       busy,
    output logic       res_valid,
    input  logic       res_ack,
    output logic [8:0] err_count,
    output logic       first_fail_vld,
    output logic [7:0] first_fail_pat
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Maximal-length Fibonacci step, taps 8,6,5,4: visits all 255 nonzero values.
    function automatic logic [7:0] lfsr_next(input logic [7:0] p);
        return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
    endfunction

    logic [1:0] state_r, state_s;
    logic [7:0] pat_r, pat_s;
    logic       mode_r, mode_s;
    logic [7:0] cnt_r, cnt_s;
    logic       busy_r, busy_s;
    logic       res_valid_r, res_valid_s;
    logic [8:0] err_count_r, err_count_s;
    logic       ffv_r, ffv_s;
    logic [7:0] ffp_r, ffp_s;
    logic       last_s;

    // The LFSR sweep takes one sample fewer than the exhaustive one, since 8'h00 is skipped.
    always_comb begin
        if (mode_r) begin
            last_s = (cnt_r == 8'd254);
        end else begin
            last_s = (cnt_r == 8'd255);
        end
    end

    // Next-state and next-output logic for the sweep controller.
    always_comb begin
        state_s     = state_r;
        pat_s       = pat_r;
        mode_s      = mode_r;
        cnt_s       = cnt_r;
        busy_s      = busy_r;
        res_valid_s = res_valid_r;
        err_count_s = err_count_r;
        ffv_s       = ffv_r;
        ffp_s       = ffp_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (mode) begin
                        pat_s = (seed == 8'h00) ? 8'h01 : seed;
                    end else begin
                        pat_s = 8'h00;
                    end
                    mode_s      = mode;
                    cnt_s       = 8'd0;
                    err_count_s = 9'd0;
                    ffv_s       = 1'b0;
                    ffp_s       = 8'h00;
                    busy_s      = 1'b1;
                    state_s     = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    if (err_in) begin
                        err_count_s = err_count_r + 9'd1;
                        if (!ffv_r) begin
                            ffv_s = 1'b1;
                            ffp_s = pat_r;
                        end else begin
                            ffp_s = ffp_r;
                        end
                    end else begin
                        err_count_s = err_count_r;
                    end
                    // The final pattern stays on a/b so the bus reflects the last sample taken.
                    if (last_s) begin
                        busy_s      = 1'b0;
                        res_valid_s = 1'b1;
                        state_s     = ST_DONE;
                    end else begin
                        pat_s = mode_r ? lfsr_next(pat_r) : (pat_r + 8'd1);
                        cnt_s = cnt_r + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                if (res_ack) begin
                    res_valid_s = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    res_valid_s = 1'b1;
                end
            end
            default: begin
                busy_s      = 1'b0;
                res_valid_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pat_r       <= 8'h00;
            mode_r      <= 1'b0;
            cnt_r       <= 8'd0;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
            err_count_r <= 9'd0;
            ffv_r       <= 1'b0;
            ffp_r       <= 8'h00;
        end else begin
            state_r     <= state_s;
            pat_r       <= pat_s;
            mode_r      <= mode_s;
            cnt_r       <= cnt_s;
            busy_r      <= busy_s;
            res_valid_r <= res_valid_s;
            err_count_r <= err_count_s;
            ffv_r       <= ffv_s;
            ffp_r       <= ffp_s;
        end
    end

    assign a              = pat_r[3:0];
    assign b              = pat_r[7:4];
    assign busy           = busy_r;
    assign res_valid      = res_valid_r;
    assign err_count      = err_count_r;
    assign first_fail_vld = ffv_r;
    assign first_fail_pat = ffp_r;

endmodule

// File: doc/app_pattern_driver.md
APP_PATTERN_DRIVER -- requirements
Module: app_pattern_driver

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 Port list, clock and reset first (name  direction  width  meaning):
 clk  input  1  rising-edge clock
 rst_n  input  1  asynchronous active-low reset
 start  input  1  request a sweep; accepted only in IDLE
 mode  input  1  0 = exhaustive sweep, 1 = LFSR sweep; sampled with start
 seed  input  8  LFSR start value; sampled with start
 abort  input  1  cancel a running sweep
 err_in  input  1  error flag returned by the approximate-adder error checker for the pattern on a/b
 a  output  4  operand A to the checker (a[0] drives a0)
 b  output  4  operand B to the checker (b[0] drives b0)
 busy  output  1  high in RUN only
 res_valid  output  1  sweep result available
 res_ack  input  1  consumer accepts the result
 err_count  output  9  number of patterns with err_in=1
 first_fail_vld  output  1  at least one failing pattern recorded
 first_fail_pat  output  8  first failing pattern, {b,a}

Function
REQ-003 The block SHALL use an internal 8-bit pattern register pat; a SHALL be pat[3:0] and b SHALL be pat[7:4], both driven from registers.
REQ-004 The FSM SHALL have states IDLE, RUN and DONE; the reset state SHALL be IDLE.
REQ-005 In IDLE with start=1: pat loads 8'h00 (mode 0) or seed (mode 1, seed 8'h00 replaced by 8'h01); err_count, first_fail_vld and first_fail_pat clear; next state RUN.
REQ-006 In RUN, the block SHALL sample err_in on every rising edge for the pattern currently on a/b and advance pat on the same edge, giving one pattern per cycle.
REQ-007 On a sampled err_in=1, err_count SHALL increment by 1; if first_fail_vld=0, first_fail_pat SHALL take pat and first_fail_vld SHALL set.
REQ-008 Exhaustive mode SHALL step pat 0..255 (+1 per cycle) and finish after the sample of 8'hFF, giving 256 samples.
REQ-009 LFSR mode SHALL step pat as {pat[6:0], pat[7]^pat[5]^pat[4]^pat[3]} and finish after 255 samples; pat SHALL never reach 8'h00.
REQ-010 When a sweep finishes, the FSM SHALL go to DONE and res_valid SHALL rise on that edge. In exhaustive mode this is 256 edges after the start-accepting edge.
REQ-011 err_count SHALL NOT wrap, because its maximum of 256 fits in 9 bits.
REQ-012 In DONE, res_valid SHALL stay at 1 and the results SHALL stay stable until res_ack=1. On that edge, res_valid SHALL clear and the FSM SHALL return to IDLE.
REQ-013 start SHALL be ignored in RUN and DONE. If start and res_ack are both high in DONE, only res_ack SHALL take effect, and start must be reasserted in IDLE.
REQ-014 abort=1 in RUN SHALL return the FSM to IDLE on the next edge with res_valid=0. err_in SHALL NOT be sampled on that edge. Partial results and a/b SHALL hold.
REQ-015 abort SHALL have no effect in IDLE or DONE. If abort and the final sample fall on the same edge, abort SHALL win.
REQ-016 In IDLE, a/b and all result outputs SHALL hold their last values.

Reset
REQ-017 While rst_n=0, immediately and independently of clk: a=0, b=0, busy=0, res_valid=0, err_count=0, first_fail_vld=0, first_fail_pat=0, state=IDLE.
REQ-018 A reset asserted mid-sweep SHALL discard the sweep. After release, the block SHALL wait in IDLE for a new start.

Verification
REQ-019 Bench: mode 0, err_in tied 0, start pulse -> res_valid rises at edge 256 after start accepted; err_count=0; first_fail_vld=0.
REQ-020 Bench: mode 0, err_in=1 when {b,a}==8'h2C or {b,a}>=8'hF0 -> err_count=17; first_fail_pat=8'h2C.
REQ-021 Bench: mode 1, seed 8'h00, err_in tied 1 -> first pattern 8'h01; 255 distinct nonzero patterns; err_count=255; first_fail_pat=8'h01.
REQ-022 Bench: abort on the 100th RUN cycle -> busy=0 next edge; res_valid stays 0; a/b hold; a new start restarts from 8'h00.
REQ-023 Bench: start pulse during RUN -> no effect. start+res_ack together in DONE -> IDLE, no new sweep.
REQ-024 Bench: rst_n low mid-sweep, asynchronous to clk -> all outputs 0 before the next edge; after release, no activity until start.
